// File: rtl/nv_ram_rd_streamer_512x256_if.sv
// Signal bundle between the RAM read streamer, its command source, the RAM read port and the stream sink.
// The master modport is the streamer side; the slave modport is everything around it.
interface nv_ram_rd_streamer_512x256_if #(
  parameter int AW = 9,
  parameter int DW = 256
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    output cmd_ready, ram_re, ram_ra, out_valid, out_data, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    input  cmd_ready, ram_re, ram_ra, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/nv_ram_rd_streamer_512x256.sv
// Burst read controller for the 512x256 RAM. The RAM's held read-address register acts as
// the output stage, so beats stream at full rate under backpressure with no data buffer.
module nv_ram_rd_streamer_512x256 #(
  parameter int AW = 9,
  parameter int DW = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  nv_ram_rd_streamer_512x256_if.master        bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   rem;
  logic [AW-1:0] ra;
  logic          valid_q;
  logic          last_q;
  logic          issue;
  logic          hs;

  always_comb begin
    issue     = (state == RUN) && (rem != '0) && (!valid_q || bus.out_ready);
    hs        = valid_q && bus.out_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = RUN;
      RUN:     if (hs && last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rem     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        ra  <= bus.cmd_addr;
        rem <= {1'b0, bus.cmd_len} + (AW+1)'(1);
      end else if (issue) begin
        ra  <= ra + AW'(1);
        rem <= rem - (AW+1)'(1);
      end
      // An issue refills the output stage; a handshake without an issue drains it.
      if (issue) begin
        valid_q <= 1'b1;
        last_q  <= (rem == (AW+1)'(1));
      end else if (hs) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.ram_re    = issue;
  assign bus.ram_ra    = ra;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = bus.ram_dout;
  assign bus.out_last  = valid_q && last_q;
endmodule

// File: tb/tb_nv_ram_rd_streamer_512x256.sv
// Self-checking bench: table of bursts plus hand sequences, with a beat scoreboard fed at command time.
module tb_nv_ram_rd_streamer_512x256;
  localparam int AW = 9;
  localparam int DW = 256;

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    bit            bp;
    int unsigned   beats;
    logic [AW-1:0] last_addr;
    int unsigned   cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] ra_q = '0;
  beat_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned beat_cnt = 0;
  logic [AW-1:0] last_seen = '0;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  vec_t vecs[5];

  nv_ram_rd_streamer_512x256_if #(.AW(AW), .DW(DW)) bus ();

  nv_ram_rd_streamer_512x256 #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    v[AW-1:0] = a;
    v[128 +: AW] = a ^ 9'h1A5;
    v[DW-AW +: AW] = ~a;
    return v;
  endfunction

  // RAM model: registered read address held while re is low, combinational data out.
  always @(posedge clk) if (bus.ram_re) ra_q <= bus.ram_ra;
  assign bus.ram_dout = mem_val(ra_q);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 256'(bus.out_valid), 256'(1));
        chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !bus.out_ready) chk("stall_no_re", 256'(bus.ram_re), 256'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat act=%h exp=none", bus.out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", bus.out_data, mem_val(e.addr));
          chk("beat_last", 256'(bus.out_last), 256'(e.last));
          beat_cnt++;
          last_seen = bus.out_data[AW-1:0];
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic push_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      beat_t b;
      b.addr = addr + AW'(i);
      b.last = (i == 32'(len));
      exp_q.push_back(b);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned k;
    bit done;
    beat_cnt = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.out_ready = 1'b1;
    push_burst(v.addr, v.len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    k = 1;
    done = 1'b0;
    while (!done && k < 2000) begin
      bus.out_ready = v.bp ? pat[k % 6] : 1'b1;
      @(negedge clk);
      if (k == 1) begin
        chk("first_re", 256'(bus.ram_re), 256'(1));
        chk("first_ra", 256'(bus.ram_ra), 256'(v.addr));
        chk("first_no_valid", 256'(bus.out_valid), 256'(0));
        chk("run_busy", 256'(bus.busy), 256'(1));
        chk("run_cmd_ready", 256'(bus.cmd_ready), 256'(0));
      end
      if (bus.cmd_ready) begin
        done = 1'b1;
        if (!v.bp) chk("done_cycle", 256'(k), 256'(v.cycles));
        chk("idle_busy", 256'(bus.busy), 256'(0));
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout act=%0d exp=%0d", k, v.cycles);
    end
    bus.out_ready = 1'b1;
    chk("beat_count", 256'(beat_cnt), 256'(v.beats));
    chk("last_addr", 256'(last_seen), 256'(v.last_addr));
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    vec_t v;
    int unsigned k;
    bit done;
    vecs[0] = '{addr: 9'd5,   len: 9'd3,   bp: 1'b0, beats: 4,   last_addr: 9'd8,   cycles: 6};
    vecs[1] = '{addr: 9'd510, len: 9'd3,   bp: 1'b0, beats: 4,   last_addr: 9'd1,   cycles: 6};
    vecs[2] = '{addr: 9'd0,   len: 9'd7,   bp: 1'b1, beats: 8,   last_addr: 9'd7,   cycles: 0};
    vecs[3] = '{addr: 9'd0,   len: 9'd511, bp: 1'b0, beats: 512, last_addr: 9'd511, cycles: 514};
    vecs[4] = '{addr: 9'd300, len: 9'd0,   bp: 1'b0, beats: 1,   last_addr: 9'd300, cycles: 3};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_last", 256'(bus.out_last), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_ram_re", 256'(bus.ram_re), 256'(0));
    chk("rst_ram_ra", 256'(bus.ram_ra), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset during the third beat of an 8-beat burst.
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 9'd0;
    bus.cmd_len   = 9'd7;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_beat0", bus.out_data, mem_val(9'd0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_beat1", bus.out_data, mem_val(9'd1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rb_beat2_valid", 256'(bus.out_valid), 256'(1));
    chk("rb_beat2", bus.out_data, mem_val(9'd2));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rb_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rb_busy", 256'(bus.busy), 256'(0));
    chk("rb_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    chk("rb_ram_re", 256'(bus.ram_re), 256'(0));
    @(negedge clk);
    chk("rb_still_idle", 256'(bus.out_valid), 256'(0));
    mon_en = 1'b1;
    v = '{addr: 9'd20, len: 9'd0, bp: 1'b0, beats: 1, last_addr: 9'd20, cycles: 3};
    run_vec(v);

    // cmd_valid held through RUN with a different command; second accepted only after completion.
    beat_cnt = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 9'd100;
    bus.cmd_len   = 9'd1;
    push_burst(9'd100, 9'd1);
    push_burst(9'd200, 9'd0);
    @(posedge clk); #1;
    bus.cmd_addr = 9'd200;
    bus.cmd_len  = 9'd0;
    k = 1;
    done = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      if (k == 1) chk("hold_cmd_ra", 256'(bus.ram_ra), 256'(100));
      if (bus.cmd_ready) done = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("hold_cmd_first_done", 256'(k), 256'(4));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    k = 1;
    done = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("hold_cmd_second_done", 256'(k), 256'(3));
    chk("hold_cmd_beats", 256'(beat_cnt), 256'(3));
    chk("hold_cmd_queue", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nv_ram_rd_streamer_512x256.md
# nv_ram_rd_streamer_512x256

Read-side controller for the 512x256 two-port RAM (registered read address, combinational data out). It accepts a burst command (start address, beat count), drives the RAM read port, and presents the entries as a valid/ready stream with a last marker. It exploits the RAM's held read-address register as its output stage, giving full throughput under backpressure with no extra data buffer.

## Interface
- AW, 9, RAM address width; depth is 2^AW = 512
- DW, 256, RAM and stream data width
- clk  input  1  core clock; also clocks the RAM
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  burst command valid
- cmd_ready  output  1  high only in IDLE
- cmd_addr  input  AW  first RAM address of the burst
- cmd_len  input  AW  beat count minus 1 (0 means 1 beat, 511 means 512 beats)
- ram_re  output  1  to RAM re; combinational
- ram_ra  output  AW  to RAM ra; registered
- ram_dout  input  DW  from RAM dout
- out_valid  output  1  stream beat valid
- out_ready  input  1  stream consumer ready
- out_data  output  DW  equals ram_dout, passed straight through
- out_last  output  1  marks the final beat of the burst
- busy  output  1  high from command accept until the last beat handshake

## Operation
- States: IDLE, RUN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: load ram_ra<=cmd_addr and rem<=cmd_len+1 (AW+1 bits), clear the beat counter, go to RUN.
- RUN: issue rule is ram_re = (rem!=0) && (!out_valid || out_ready).
  - On each issue: ram_ra<=ram_ra+1 (wraps modulo 512, so 511 is followed by 0), rem<=rem-1, out_valid<=1 next cycle.
  - On out_valid && out_ready with no issue in the same cycle: out_valid<=0.
- out_last:
  - Track issued-beat index; a flag registered alongside out_valid is set when the issued beat was the one with rem==1.
  - out_last = out_valid && that flag.
- Completion: on the out_valid && out_ready && out_last handshake, go to IDLE. cmd_ready is 1 on the next cycle.
- While out_valid=1 and out_ready=0, ram_re=0. The RAM holds its read-address register, so out_data stays stable.
- cmd_valid in RUN is ignored (cmd_ready=0).
- Writer-side rule, a caller obligation that is not checked: the address currently presented in out_data must not be written until its handshake completes, because RAM data out is combinational.

## Timing
- Reset: state=IDLE, cmd_ready=1, out_valid=0, out_last=0, busy=0, ram_re=0, ram_ra=0, rem=0. Reset applies mid-burst: the burst is dropped immediately and no further beats are issued.
- Command accepted at cycle T:
  - RUN from T+1.
  - First ram_re at T+1 with ram_ra=cmd_addr.
  - First out_valid at T+2.
- With out_ready held high: 1 beat per cycle. An N-beat burst has its last beat at T+N+1 and cmd_ready=1 at T+N+2.
- Minimum spacing between command accepts for 1-beat bursts: 3 cycles.
- Backpressure:
  - Issue resumes in the same cycle that out_ready returns high. The new beat is visible the next cycle, so there are no bubbles and no lost or duplicated beats.
- busy=1 from T+1 through the cycle of the last handshake.
- rem width is AW+1, so cmd_len=511 gives exactly 512 beats without overflow.

## Test plan
- RAM preloaded M[i]=i; cmd addr=5, len=3, out_ready=1 -> data 5,6,7,8 on consecutive cycles starting T+2; out_last on 8 only; cmd_ready=1 at T+6.
- cmd addr=510, len=3 -> beats 510,511,0,1 (address wrap); out_last on 1.
- cmd addr=0, len=7; out_ready toggles 1,0,0,1,0,1… -> exactly 0..7 delivered in order; out_data stable whenever valid&&!ready; ram_re=0 in those cycles.
- cmd len=511 from addr 0, out_ready=1 -> 512 beats, out_last only on beat 511, busy drops after it.
- rst asserted on the third beat of an 8-beat burst -> next cycle out_valid=0, busy=0, cmd_ready=1. A new cmd addr=20, len=0 then yields a single beat 20 with out_last=1.
- cmd_valid held high during RUN with a different addr -> ignored; accepted only when cmd_ready returns.
